// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data memory: RV32I access-size codes,
// controller states and the store byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte mask and replication, load lane
// selection with sign/zero extension, and alignment checking.
module dmem_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: mask and replicated data so every enabled lane sees its byte.
  always_comb begin
    byte_mask = byte_en(funct3, addr_lo);
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Alignment check for halfword and word sizes.
  always_comb begin
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Load side: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'd0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'd0, half_sel};
      F3_W:    rdata_ext = rdata_raw;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressable RV32I data memory for the MEM stage: one-cycle registered
// responses, misalign/range error flagging and a post-reset zeroing sweep.
module lsu_data_memory
  import lsu_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int INIT_SWEEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  req_idx_s, wr_idx_s;
  logic [3:0]        wr_mask_s, lane_mask_s;
  logic [31:0]       wr_data_s, lane_wdata_s, lane_rdata_s;
  logic              lane_misalign_s, out_of_range_s, bad_funct3_s, req_err_s, accept_s;

  assign req_idx_s      = req_addr[IDX_W+1:2];
  assign out_of_range_s = ((req_addr >> (IDX_W + 2)) != 32'd0);
  assign req_ready      = (state_q == ST_RUN) && !rst;
  assign accept_s       = req_valid && req_ready;
  assign req_err_s      = out_of_range_s || lane_misalign_s || bad_funct3_s;

  dmem_lane_align u_align (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .rdata_raw (mem_q[req_idx_s]),
    .byte_mask (lane_mask_s),
    .wdata_rep (lane_wdata_s),
    .rdata_ext (lane_rdata_s),
    .misalign  (lane_misalign_s)
  );

  // Stores accept only B/H/W; loads additionally accept BU/HU.
  always_comb begin
    if (req_we) begin
      case (req_funct3)
        F3_B, F3_H, F3_W: bad_funct3_s = 1'b0;
        default:          bad_funct3_s = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_funct3_s = 1'b0;
        default:                        bad_funct3_s = 1'b1;
      endcase
    end
  end

  // Controller: sweep sequencing, request handling and the write port.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'd0;
    rsp_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    wr_idx_s     = req_idx_s;
    wr_mask_s    = 4'b0000;
    wr_data_s    = lane_wdata_s;
    if (rst) begin
      state_d      = (INIT_SWEEP != 0) ? ST_INIT : ST_RUN;
      idx_d        = '0;
      err_sticky_d = 1'b0;
      err_addr_d   = 32'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          wr_idx_s  = idx_q;
          wr_mask_s = 4'b1111;
          wr_data_s = 32'd0;
          if (idx_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            rsp_valid_d = 1'b1;
            if (req_err_s) begin
              rsp_err_d    = 1'b1;
              err_sticky_d = 1'b1;
              err_addr_d   = req_addr;
            end else if (req_we) begin
              wr_mask_s = lane_mask_s;
            end else begin
              rsp_rdata_d = lane_rdata_s;
            end
          end else begin
            rsp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    idx_q        <= idx_d;
    rsp_valid_q  <= rsp_valid_d;
    rsp_rdata_q  <= rsp_rdata_d;
    rsp_err_q    <= rsp_err_d;
    err_sticky_q <= err_sticky_d;
    err_addr_q   <= err_addr_d;
  end

  // Byte-masked array write; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_mask_s[b]) begin
        mem_q[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;
  assign busy       = (state_q == ST_INIT);

endmodule
